// File: rtl/avgpool_sequencer.sv
// avgpool_sequencer: 2x2 pooling sequencer over a single-port source memory with backpressured writes.
// Averages by default; defining POOL_MAX_EN switches the datapath to a running signed maximum.
module avgpool_sequencer #(
   parameter int WIDTH  = 28,
   parameter int HEIGHT = 28,
   parameter int DEPTH  = 6,
   parameter int DW     = 16,
   parameter int RAW    = $clog2(WIDTH*HEIGHT*DEPTH),
   parameter int WAW    = $clog2((WIDTH/2)*(HEIGHT/2)*DEPTH)
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           start_i,
   output logic           busy_o,
   output logic           done_o,
   output logic           rd_en_o,
   output logic [RAW-1:0] rd_addr_o,
   input  logic [DW-1:0]  rd_data_i,
   output logic           wr_en_o,
   input  logic           wr_ready_i,
   output logic [WAW-1:0] wr_addr_o,
   output logic [DW-1:0]  wr_data_o
);
   localparam int QM = WIDTH/2 - 1;
   localparam int RM = HEIGHT/2 - 1;
   localparam int CM = DEPTH - 1;
   localparam int QW = $clog2(WIDTH/2 + 1);
   localparam int RW = $clog2(HEIGHT/2 + 1);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, LAST, WR, DONE} state_t;
   state_t st_q;

   logic [QW-1:0] q_q, q_d;
   logic [RW-1:0] r_q, r_d;
   logic [CW-1:0] c_q, c_d;
   logic last_w;
   logic signed [DW+1:0] acc_q, acc_d, ext;
   logic [DW-1:0] res;

   function automatic logic [RAW-1:0] raddr(input logic [CW-1:0] c, input logic [RW-1:0] r,
                                            input logic [QW-1:0] q, input int off);
      return RAW'(int'(c)*WIDTH*HEIGHT + int'(r)*2*WIDTH + int'(q)*2 + off);
   endfunction

   function automatic logic [WAW-1:0] waddr(input logic [CW-1:0] c, input logic [RW-1:0] r,
                                            input logic [QW-1:0] q);
      return WAW'(int'(c)*(WIDTH/2)*(HEIGHT/2) + int'(r)*(WIDTH/2) + int'(q));
   endfunction

   always_comb begin
      last_w = q_q == QW'(QM) && r_q == RW'(RM) && c_q == CW'(CM);
      q_d = q_q == QW'(QM) ? '0 : q_q + 1'b1;
      r_d = q_q != QW'(QM) ? r_q : (r_q == RW'(RM) ? '0 : r_q + 1'b1);
      c_d = (q_q == QW'(QM) && r_q == RW'(RM)) ? c_q + 1'b1 : c_q;
      ext = {{2{rd_data_i[DW-1]}}, rd_data_i};
`ifdef POOL_MAX_EN
      acc_d = (st_q == RD1 || ext > acc_q) ? ext : acc_q;
      res = acc_d[DW-1:0];
`else
      acc_d = acc_q + ext;
      res = acc_d[DW+1:2];
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q      <= IDLE;
         q_q       <= '0;
         r_q       <= '0;
         c_q       <= '0;
         acc_q     <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         rd_en_o   <= 1'b0;
         rd_addr_o <= '0;
         wr_en_o   <= 1'b0;
         wr_addr_o <= '0;
         wr_data_o <= '0;
      end else begin
         done_o <= 1'b0;
         case (st_q)
            IDLE: if (start_i) begin
               st_q      <= RD0;
               busy_o    <= 1'b1;
               rd_en_o   <= 1'b1;
               rd_addr_o <= raddr(c_q, r_q, q_q, 0);
               acc_q     <= '0;
            end
            RD0: begin
               st_q      <= RD1;
               rd_addr_o <= raddr(c_q, r_q, q_q, 1);
            end
            RD1: begin
               st_q      <= RD2;
               rd_addr_o <= raddr(c_q, r_q, q_q, WIDTH);
               acc_q     <= acc_d;
            end
            RD2: begin
               st_q      <= RD3;
               rd_addr_o <= raddr(c_q, r_q, q_q, WIDTH + 1);
               acc_q     <= acc_d;
            end
            RD3: begin
               st_q    <= LAST;
               rd_en_o <= 1'b0;
               acc_q   <= acc_d;
            end
            LAST: begin
               st_q      <= WR;
               acc_q     <= acc_d;
               wr_en_o   <= 1'b1;
               wr_addr_o <= waddr(c_q, r_q, q_q);
               wr_data_o <= res;
            end
            WR: if (wr_ready_i) begin
               wr_en_o <= 1'b0;
               if (last_w) begin
                  st_q   <= DONE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
                  q_q    <= '0;
                  r_q    <= '0;
                  c_q    <= '0;
               end else begin
                  // next window's first read issues straight out of the accepted write
                  st_q      <= RD0;
                  rd_en_o   <= 1'b1;
                  rd_addr_o <= raddr(c_d, r_d, q_d, 0);
                  acc_q     <= '0;
                  q_q       <= q_d;
                  r_q       <= r_d;
                  c_q       <= c_d;
               end
            end
            default: st_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_avgpool_sequencer.sv
// tb_avgpool_sequencer: directed checks of a 2x2x1 and a 4x4x2 instance.
module tb_avgpool_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        start2 = 1'b0, ready2 = 1'b1;
   logic        busy2, done2, rd_en2, wr_en2;
   logic [1:0]  rd_addr2;
   logic [0:0]  wr_addr2;
   logic [15:0] rd_data2 = '0, wr_data2;
   logic [15:0] mem2 [4];

   logic        start4 = 1'b0, ready4 = 1'b1;
   logic        busy4, done4, rd_en4, wr_en4;
   logic [4:0]  rd_addr4;
   logic [2:0]  wr_addr4;
   logic [15:0] rd_data4 = '0, wr_data4;

   int vecs = 0, errs = 0;
   logic clr = 1'b0;
   int nw = 0, nr = 0, n;
   logic [15:0] wa [64];
   logic [15:0] wd [64];
   logic [15:0] ra [64];
   logic [15:0] exp_d [8] = '{16'd2, 16'd4, 16'd10, 16'd12, 16'd18, 16'd20, 16'd26, 16'd28};

   avgpool_sequencer #(.WIDTH(2), .HEIGHT(2), .DEPTH(1), .DW(16), .WAW(1)) u2 (
      .clk(clk), .rst(rst), .start_i(start2), .busy_o(busy2), .done_o(done2),
      .rd_en_o(rd_en2), .rd_addr_o(rd_addr2), .rd_data_i(rd_data2),
      .wr_en_o(wr_en2), .wr_ready_i(ready2), .wr_addr_o(wr_addr2), .wr_data_o(wr_data2));

   avgpool_sequencer #(.WIDTH(4), .HEIGHT(4), .DEPTH(2), .DW(16)) u4 (
      .clk(clk), .rst(rst), .start_i(start4), .busy_o(busy4), .done_o(done4),
      .rd_en_o(rd_en4), .rd_addr_o(rd_addr4), .rd_data_i(rd_data4),
      .wr_en_o(wr_en4), .wr_ready_i(ready4), .wr_addr_o(wr_addr4), .wr_data_o(wr_data4));

   always @(posedge clk) begin
      rd_data2 <= mem2[rd_addr2];
      rd_data4 <= 16'(rd_addr4);
   end

   always @(posedge clk) begin
      if (clr) begin
         nw <= 0;
         nr <= 0;
      end else begin
         if (wr_en4 && ready4 && nw < 64) begin
            wa[nw] <= 16'(wr_addr4);
            wd[nw] <= wr_data4;
            nw <= nw + 1;
         end
         if (rd_en4 && nr < 64) begin
            ra[nr] <= 16'(rd_addr4);
            nr <= nr + 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run2(input string tag, input logic [15:0] a, b, c, d, input logic [15:0] exp);
      mem2[0] = a; mem2[1] = b; mem2[2] = c; mem2[3] = d;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      repeat (5) tick();
      chk(tag, {wr_en2, wr_data2}, {1'b1, exp});
      tick();
      chk({tag, "_done"}, done2, 1'b1);
      tick();
   endtask

   task automatic pulse4();
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
   endtask

   initial begin
      repeat (2) tick();
      chk("rst_u2", {busy2, done2, rd_en2, rd_addr2, wr_en2, wr_addr2, wr_data2}, 0);
      chk("rst_u4", {busy4, done4, rd_en4, rd_addr4, wr_en4, wr_addr4, wr_data4}, 0);
      rst = 1'b0;
      tick();

      mem2[0] = 16'd4; mem2[1] = 16'd8; mem2[2] = 16'd12; mem2[3] = 16'd16;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rd_c%0d", i + 1), {rd_en2, rd_addr2, busy2}, {1'b1, 2'(i), 1'b1});
         tick();
      end
      chk("last_c5", {rd_en2, wr_en2, busy2}, 3'b001);
      tick();
      chk("wr_c6", {wr_en2, wr_addr2, wr_data2}, {1'b1, 1'b0, 16'd10});
      tick();
      chk("done_c7", {done2, busy2, wr_en2}, 3'b100);
      tick();
      chk("idle_c8", {done2, busy2}, 2'b00);

      run2("neg_avg", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFE);
`ifdef POOL_MAX_EN
      run2("max_mix", 16'd3, 16'hFFF9, 16'd9, 16'd2, 16'd9);
`else
      run2("avg_mix", 16'd3, 16'hFFF9, 16'd9, 16'd2, 16'd1);
`endif

      // pass with a 3-cycle stall on the first write and a start pulse while busy
      clr = 1'b1; tick(); clr = 1'b0;
      ready4 = 1'b0;
      pulse4();
      repeat (5) tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) ready4 = 1'b1;
         chk($sformatf("stall_%0d", i), {wr_en4, rd_en4, wr_addr4, wr_data4}, {2'b10, 3'd0, 16'd2});
         tick();
      end
      chk("stall_one_wr", nw, 1);
      chk("post_stall_rd", {rd_en4, rd_addr4}, {1'b1, 5'd2});
      pulse4();
      n = 0;
      while (!done4 && n < 200) begin tick(); n++; end
      chk("passA_done_seen", done4, 1'b1);
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      chk("start_in_done_ignored", {busy4, rd_en4}, 2'b00);
      chk("passA_nwrites", nw, 8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("passA_w%0d", i), {wa[i], wd[i]}, {16'(i), exp_d[i]});
      chk("w5_reads", {ra[20], ra[21], ra[22], ra[23]}, {16'd18, 16'd19, 16'd22, 16'd23});
      chk("passA_nreads", nr, 32);

      // unstalled pass timing
      clr = 1'b1; tick(); clr = 1'b0;
      pulse4();
      n = 0;
      while (!done4 && n < 200) begin tick(); n++; end
      chk("pass_48", n, 48);
      chk("passB_nwrites", nw, 8);

      // reset during RD2 of window 3
      clr = 1'b1; tick(); clr = 1'b0;
      pulse4();
      repeat (20) tick();
      chk("w3_rd2", {rd_en4, rd_addr4}, {1'b1, 5'd14});
      rst = 1'b1;
      tick();
      chk("mid_rst", {busy4, done4, rd_en4, rd_addr4, wr_en4, wr_addr4, wr_data4}, 0);
      rst = 1'b0;
      repeat (3) tick();
      chk("idle_after_rst", {busy4, rd_en4, wr_en4}, 3'b000);
      chk("rst_writes", nw, 3);
      pulse4();
      chk("restart_rd", {rd_en4, rd_addr4}, {1'b1, 5'd0});
      repeat (5) tick();
      chk("restart_wr", {wr_en4, wr_addr4, wr_data4}, {1'b1, 3'd0, 16'd2});

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/avgpool_sequencer.md
# avgpool_sequencer

Sequencer for the 2x2 pooling stage between the conv feature-map buffer and the next layer's input buffer. On `start` it walks every channel and 2x2 window of a WIDTH x HEIGHT x DEPTH map in a single-port source memory, reads the four pixels of each window and accumulates them. It writes one pooled result per window into a destination memory, with backpressure on the write side. It replaces the wide flattened-bus pooling path with a time-multiplexed, memory-addressed one.

## Interface
- WIDTH, 28, input map columns per channel
- HEIGHT, 28, input map rows per channel
- DEPTH, 6, channel count
- DW, 16, pixel width, signed two's complement
- RAW, $clog2(WIDTH*HEIGHT*DEPTH), source address width
- WAW, $clog2((WIDTH/2)*(HEIGHT/2)*DEPTH), destination address width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a pass; sampled only in IDLE
- busy  out  1  high in RD0-RD3, LAST, WR
- done  out  1  one-cycle pulse after the final write is accepted
- rd_en  out  1  source read strobe
- rd_addr  out  RAW  source address
- rd_data  in  DW  source data, valid exactly one cycle after rd_en
- wr_en  out  1  destination write request, held until accepted
- wr_ready  in  1  destination accepts when wr_en && wr_ready at a rising edge
- wr_addr  out  WAW  destination address
- wr_data  out  DW  pooled pixel

## Operation
- Counters: channel c in 0..DEPTH-1, output row r in 0..HEIGHT/2-1, output column q in 0..WIDTH/2-1. Scan order is q fastest, then r, then c.
- Odd WIDTH/HEIGHT: the last column/row is never read (floor).
- Window base: b = c*WIDTH*HEIGHT + 2r*WIDTH + 2q. Reads go to b, b+1, b+WIDTH, b+WIDTH+1, in that order.
- Destination address: c*(WIDTH/2)*(HEIGHT/2) + r*(WIDTH/2) + q.
- FSM:
  - IDLE: on start go to RD0.
  - RD0-RD3: rd_en=1, one read per state; each state advances unconditionally to the next.
  - RD3 goes to LAST, which captures the 4th datum (rd_en=0).
  - LAST goes to WR.
  - WR: hold wr_en until wr_ready. When accepted, advance the counters and go to RD0. If the accepted write was the last window, go to DONE.
  - DONE: done=1, then IDLE.
- Accumulator is DW+2 bits, signed. It is cleared when RD0 is entered and adds the sign-extended rd_data in RD1, RD2, RD3 and LAST.
- wr_data = acc >>> 2 (arithmetic shift, floor toward -inf), truncated to DW bits; no saturation is needed.
- wr_addr and wr_data are stable for the whole time wr_en is high.
- start is ignored outside IDLE, including the DONE cycle.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0; FSM=IDLE; all counters and the accumulator are 0.
- start is sampled at edge E0. rd_en is high in cycles 1-4, LAST is cycle 5, wr_en is high from cycle 6.
- Each window takes 6 cycles when wr_ready stays high, plus 1 cycle per stall cycle.
- Full pass with no stalls: 6*DEPTH*(WIDTH/2)*(HEIGHT/2) cycles from the first rd_en to the last accepted write. done follows on the next cycle.
- Stalls in WR: rd_en stays 0 and the counters are frozen.
- Reset mid-pass: abort immediately and return to reset values. No partial write is emitted after rst is released. A new start is required.

## Configuration
- POOL_MAX_EN:
  - When defined, the accumulator is replaced by a running signed maximum: the 1st datum is loaded in RD1, then compare-and-keep in RD2, RD3 and LAST. wr_data is that maximum with no shift.
  - When undefined, the block does averaging as above.
  - The FSM, addressing and timing are identical in both modes.

## Test plan
- WIDTH=HEIGHT=2, DEPTH=1, pixels 4,8,12,16, wr_ready=1, start at E0: rd_en cycles 1-4 with addresses 0,1,2,3; wr_en in cycle 6 with wr_addr=0, wr_data=10; done in cycle 7; busy low from cycle 7.
- Same setup, pixels -1,-1,-1,-2: wr_data = 16'hFFFE (-5>>>2 = -2).
- WIDTH=HEIGHT=4, DEPTH=2, pixel value = its address, wr_ready=1: 8 writes. Write 5 (c=1, r=0, q=1) reads addresses 18,19,22,23, has wr_addr=5 and wr_data=20. done comes 48 cycles after the first rd_en.
- Hold wr_ready=0 for 3 cycles on the first write: wr_en stays high for 4 cycles with constant addr and data; no rd_en during the stall; exactly one write is accepted.
- Pulse start while busy: no restart, and the write sequence is unchanged. Assert rst during RD2 of window 3: all outputs 0 next cycle and FSM in IDLE. A fresh start then restarts at window 0.
- With POOL_MAX_EN and pixels 3,-7,9,2: wr_data=9.
